history_serializer: RTL and testbench
=====================================

HISTORY_SERIALIZER -- requirements
Module: history_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default -1, meaning entry width in bits; it must be overridden.
REQ-002 The block SHALL have parameter HISTORY_L, default -1, meaning number of history entries; it must be overridden and be >= 2.
REQ-003 The block SHALL have clk_in  input  1  single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have reset_in  input  1  synchronous active-high reset.
REQ-005 The block SHALL have hist_data_in  input  DATA_W x [HISTORY_L-1:0] unpacked  history entries; index 0 is the newest.
REQ-006 The block SHALL have hist_valid_in  input  HISTORY_L  per-entry valid; set bits are contiguous from bit 0.
REQ-007 The block SHALL have start_in  input  1  single-cycle request to snapshot and stream the history.
REQ-008 The block SHALL have busy_out  output  1  high from the cycle after an accepted start until done_out.
REQ-009 The block SHALL have data_out  output  DATA_W  current streamed entry.
REQ-010 The block SHALL have entry_valid_out  output  1  snapshot valid bit of the current entry.
REQ-011 The block SHALL have index_out  output  clog2(HISTORY_L)  history index of the current entry.
REQ-012 The block SHALL have valid_out  output  1  stream beat valid.
REQ-013 The block SHALL have ready_in  input  1  downstream ready.
REQ-014 The block SHALL have last_out  output  1  marks the final beat of a snapshot.
REQ-015 The block SHALL have done_out  output  1  one-cycle pulse after the final beat, or after an empty snapshot.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-017 In IDLE with start_in=1, the block SHALL register hist_data_in and hist_valid_in into an internal snapshot, clear the index to 0, and move to SEND; if no beat will be sent, it SHALL move to DONE instead.
REQ-018 valid_out SHALL first assert one cycle after the accepted start_in, giving a start-to-first-beat latency of 1.
REQ-019 A beat SHALL transfer when valid_out=1 and ready_in=1 in the same cycle.
REQ-020 While valid_out=1 and ready_in=0, data_out, entry_valid_out, index_out and last_out SHALL hold stable.
REQ-021 In SEND, valid_out SHALL be 1 every cycle, so back-to-back transfers run at one beat per cycle.
REQ-022 Entries SHALL stream in ascending index order, 0 first.
REQ-023 On a non-last transfer the index SHALL increment; on a last transfer the FSM SHALL move to DONE.
REQ-024 DONE SHALL last one cycle, with done_out=1 and valid_out=0, then return to IDLE.
REQ-025 start_in SHALL be ignored in SEND and DONE; no queuing.
REQ-026 The snapshot SHALL be immune to hist_data_in and hist_valid_in changes after capture.
REQ-027 index_out SHALL never exceed HISTORY_L-1, and the index SHALL not wrap.
REQ-028 busy_out SHALL equal (state != IDLE).

Reset
REQ-029 reset_in=1 SHALL force the FSM to IDLE in any state, including mid-stream, discarding the snapshot.
REQ-030 During and after reset, valid_out, last_out, done_out, busy_out, entry_valid_out, index_out and data_out SHALL all be 0.
REQ-031 A start_in asserted in the same cycle as reset_in SHALL be ignored.

Configuration
REQ-032 Macro HISTORY_SERIALIZER_SKIP_INVALID_EN SHALL select whether invalid entries are streamed.
REQ-033 With HISTORY_SERIALIZER_SKIP_INVALID_EN defined:
- only entries whose snapshot valid bit is 1 SHALL be streamed;
- last_out SHALL assert on index N-1, where N is the count of valid entries;
- entry_valid_out SHALL be constant 1;
- a snapshot with N=0 SHALL go IDLE->DONE, with no beat and done_out one cycle after start_in.
REQ-034 Without HISTORY_SERIALIZER_SKIP_INVALID_EN:
- all HISTORY_L entries SHALL be streamed regardless of valid;
- last_out SHALL assert on index HISTORY_L-1;
- entry_valid_out SHALL carry the snapshot valid bit;
- the IDLE->DONE shortcut SHALL never occur.

Verification
REQ-035 DATA_W=8, HISTORY_L=4, macro off; history {0x11,0x22,0x33,0x44}, valid 4'b0011, start, ready_in=1 -> beats at cycles 1-4 carry data 11,22,33,44, entry_valid 1,1,0,0, last on beat 4, done at cycle 5.
REQ-036 Same stimulus, macro on -> two beats (0x11, 0x22), last on 0x22, done at cycle 3.
REQ-037 Macro on, valid 4'b0000, start -> no valid_out, done_out at cycle 1, busy_out high for 1 cycle.
REQ-038 Macro off, ready_in low for 3 cycles on beat index 1 -> data 0x22 and index 1 held stable; no beat lost or duplicated.
REQ-039 Macro off, history changed and start re-pulsed during SEND -> streamed values equal the original snapshot; second start ignored.
REQ-040 Macro off, reset_in at beat index 2 -> next cycle all outputs 0 and FSM in IDLE; a subsequent start streams from index 0.

Source files
------------

// File: rtl/history_serializer.sv
// Snapshots a history buffer on start_in and streams it out one entry per beat over valid/ready.
// Define HISTORY_SERIALIZER_SKIP_INVALID_EN to stream only the valid entries instead of all of them.
module history_serializer #(
  parameter int DATA_W    = -1,
  parameter int HISTORY_L = -1,
  localparam int IDX_W    = (HISTORY_L > 1) ? $clog2(HISTORY_L) : 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] hist_data_in [HISTORY_L-1:0],
  input  logic [HISTORY_L-1:0] hist_valid_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic [DATA_W-1:0] data_out,
  output logic              entry_valid_out,
  output logic [IDX_W-1:0]  index_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              last_out,
  output logic              done_out
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic              capture;
  logic              is_last;
  logic              xfer;
  logic              empty_snap;
  logic [DATA_W-1:0] snap_data [HISTORY_L-1:0];

  assign capture = (state == IDLE) && start_in;
  assign xfer    = (state == SEND) && ready_in;
  assign is_last = (idx == last_idx);

  // Per-entry snapshot registers; only loaded on an accepted start.
  for (genvar g = 0; g < HISTORY_L; g++) begin : g_snap
    always_ff @(posedge clk_in) begin
      if (reset_in)     snap_data[g] <= '0;
      else if (capture) snap_data[g] <= hist_data_in[g];
    end
  end

`ifdef HISTORY_SERIALIZER_SKIP_INVALID_EN
  localparam int CNT_W = $clog2(HISTORY_L + 1);

  logic [CNT_W-1:0] cap_count;
  logic             run;

  // Length of the valid run starting at entry 0; stopping at the first hole
  // guarantees no invalid entry is ever streamed.
  always_comb begin
    cap_count = '0;
    run       = 1'b1;
    for (int i = 0; i < HISTORY_L; i++) begin
      run = run & hist_valid_in[i];
      if (run) cap_count = CNT_W'(i + 1);
    end
  end

  assign empty_snap = (cap_count == '0);

  always_ff @(posedge clk_in) begin
    if (reset_in)     last_idx <= '0;
    else if (capture) last_idx <= empty_snap ? '0 : IDX_W'(cap_count - CNT_W'(1));
  end

  assign entry_valid_out = valid_out;
`else
  logic [HISTORY_L-1:0] snap_valid;

  always_ff @(posedge clk_in) begin
    if (reset_in)     snap_valid <= '0;
    else if (capture) snap_valid <= hist_valid_in;
  end

  assign empty_snap      = 1'b0;
  assign last_idx        = IDX_W'(HISTORY_L - 1);
  assign entry_valid_out = valid_out & snap_valid[idx];
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start_in) state_d = empty_snap ? DONE : SEND;
      SEND: if (ready_in && is_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index saturates at the last entry; leaving SEND is what ends the stream.
  always_ff @(posedge clk_in) begin
    if (reset_in)              idx <= '0;
    else if (capture)          idx <= '0;
    else if (xfer && !is_last) idx <= idx + IDX_W'(1);
  end

  // Outputs are forced to zero outside SEND so idle/reset values are clean.
  assign valid_out = (state == SEND);
  assign busy_out  = (state != IDLE);
  assign done_out  = (state == DONE);
  assign last_out  = valid_out & is_last;
  assign data_out  = valid_out ? snap_data[idx] : '0;
  assign index_out = valid_out ? idx : '0;

endmodule

// File: tb/tb_history_serializer.sv
// Randomized self-checking bench for history_serializer (DATA_W=8, HISTORY_L=4); follows the DUT build macro.
module tb_history_serializer;
  localparam int DW = 8;
  localparam int HL = 4;
`ifdef HISTORY_SERIALIZER_SKIP_INVALID_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] hist_data [HL-1:0];
  logic [HL-1:0] hist_valid;
  logic          start;
  logic          busy;
  logic [DW-1:0] data;
  logic          entry_valid;
  logic [1:0]    index;
  logic          valid;
  logic          ready;
  logic          last;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic       ev;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  always #5 clk = ~clk;

  history_serializer #(.DATA_W(DW), .HISTORY_L(HL)) dut (
    .clk_in(clk), .reset_in(reset), .hist_data_in(hist_data), .hist_valid_in(hist_valid),
    .start_in(start), .busy_out(busy), .data_out(data), .entry_valid_out(entry_valid),
    .index_out(index), .valid_out(valid), .ready_in(ready), .last_out(last), .done_out(done)
  );

  // Drives one snapshot through the DUT and checks every cycle against a beat list
  // built from the stream rules. Inputs are scrambled and start is re-pulsed while
  // busy to show the snapshot is frozen and extra starts are ignored.
  task automatic run_stream(input logic [7:0] d [HL-1:0], input logic [HL-1:0] v,
                            input int ready_pct, input int stall_idx, input string tag);
    beat_t q[$];
    beat_t b;
    beat_t e;
    int    nbeats, cyc, stalls;
    bit    expect_done, done_seen;
    for (int i = 0; i < HL; i++) begin
      if (!SKIP || v[i]) begin
        b.d = d[i]; b.ev = v[i]; b.idx = 2'(i); b.last = 1'b0;
        q.push_back(b);
      end
    end
    if (q.size() > 0) q[q.size()-1].last = 1'b1;
    nbeats = q.size();

    @(negedge clk);
    hist_data = d; hist_valid = v; start = 1'b1; ready = 1'b1;
    expect_done = (nbeats == 0);
    cyc = 0; stalls = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      for (int i = 0; i < HL; i++) hist_data[i] = 8'($urandom);
      hist_valid = 4'($urandom);
      n_checks++;
      if (done !== expect_done) begin
        n_fail++; $display("FAIL %s done_timing cyc=%0d: got %b expected %b", tag, cyc, done, expect_done);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s busy cyc=%0d: got %b expected 1", tag, cyc, busy);
      end
      if (done === 1'b1) begin
        done_seen = 1'b1;
        n_checks++;
        if (valid !== 1'b0) begin
          n_fail++; $display("FAIL %s valid_in_done: got %b expected 0", tag, valid);
        end
        if (ready_pct == 100 && stall_idx < 0) begin
          n_checks++;
          if (cyc != nbeats + 1) begin
            n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, cyc, nbeats + 1);
          end
        end
      end else begin
        n_checks++;
        if (valid !== 1'b1) begin
          n_fail++; $display("FAIL %s valid cyc=%0d: got %b expected 1", tag, cyc, valid);
        end else if (q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_beat cyc=%0d: got idx %0d expected none", tag, cyc, index);
        end else begin
          e = q[0];
          n_checks++;
          if ({data, entry_valid, index, last} !== {e.d, e.ev, e.idx, e.last}) begin
            n_fail++;
            $display("FAIL %s beat cyc=%0d: got d=%h ev=%b idx=%0d last=%b expected d=%h ev=%b idx=%0d last=%b",
                     tag, cyc, data, entry_valid, index, last, e.d, e.ev, e.idx, e.last);
          end
        end
        if (stall_idx >= 0 && q.size() > 0 && int'(q[0].idx) == stall_idx && stalls < 3) begin
          ready = 1'b0; stalls++;
        end else begin
          ready = ($urandom_range(99) < ready_pct);
        end
        if (valid === 1'b1 && ready && q.size() > 0) begin
          void'(q.pop_front());
          if (q.size() == 0) expect_done = 1'b1;
        end
        start = ($urandom_range(3) == 0);
      end
    end
    start = 1'b0;
    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no done_out expected done within 200 cycles", tag);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL %s return_idle: got busy/valid/done=%b expected 000", tag, {busy, valid, done});
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; ready = 1'b1; hist_valid = '1;
    for (int i = 0; i < HL; i++) hist_data[i] = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({valid, last, done, busy, entry_valid, index, data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {valid, last, done, busy, entry_valid, index, data});
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_start_ignored: got busy/valid/done=%b expected 000", {busy, valid, done});
    end
  endtask

  task automatic test_directed();
    logic [7:0] d [HL-1:0];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    run_stream(d, 4'b0011, 100, -1, "directed");
  endtask

  task automatic test_empty();
    logic [7:0] d [HL-1:0];
    for (int i = 0; i < HL; i++) d[i] = 8'(8'h50 + i);
    run_stream(d, 4'b0000, 100, -1, "empty");
  endtask

  task automatic test_backpressure();
    logic [7:0] d [HL-1:0];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    run_stream(d, 4'b0011, 100, 1, "stall_idx1");
  endtask

  task automatic test_random();
    logic [7:0]    d [HL-1:0];
    logic [HL-1:0] v;
    int            n;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < HL; i++) d[i] = 8'($urandom);
      n = $urandom_range(HL);
      v = 4'((5'd1 << n) - 5'd1);
      run_stream(d, v, 60, -1, "random");
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] d [HL-1:0];
    int         cyc;
    for (int i = 0; i < HL; i++) d[i] = 8'(8'hC0 + i);
    @(negedge clk);
    hist_data = d; hist_valid = 4'b1111; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(valid === 1'b1 && index === 2'd2) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 20) begin
      n_fail++; $display("FAIL midreset_reach_idx2: got idx %0d expected 2", index);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({valid, last, done, busy, entry_valid, index, data} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {valid, last, done, busy, entry_valid, index, data});
    end
    reset = 1'b0;
    run_stream(d, 4'b0011, 100, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_empty();
    test_backpressure();
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
